// File: rtl/clk_sched_pkg.sv
// Shared types and helpers for the divided-clock scheduler.
// Channel FSM states, the pending config request and ratio clamping.
package clk_sched_pkg;

    localparam int DIV_W_MAX = 16;
    localparam int CH_W_MAX  = 8;
    localparam int DIV_MIN   = 1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic [DIV_W_MAX-1:0] div;
        logic                 en;
    } cfg_req_t;

    // A ratio of zero has no meaning; treat it as the fastest legal ratio.
    function automatic logic [DIV_W_MAX-1:0] div_clamp(
        input logic [DIV_W_MAX-1:0] d
    );
        return (d == '0) ? DIV_W_MAX'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: idle/run FSM, period counter,
// registered div_clk and tick, config applied only on period boundaries.
module clk_div_chan
    import clk_sched_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_apply_v,
    input  logic [DIV_W-1:0] i_apply_div,
    input  logic             i_apply_en,
    output logic             o_applied,
    output logic             o_active,
    output logic             o_tick,
    output logic             o_div_clk
);

    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] w_count_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_half_nxt;
    logic             r_div_clk;
    logic             w_div_clk_nxt;
    logic             w_tick;
    logic             w_applied;

    // Last cycle of a period, decoded from registered state only.
    assign w_tick = (r_state == CH_RUN) &&
                    (r_count == r_div - DIV_W'(1));

    // Next state: count through the period, take config at boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_div_nxt   = r_div;
        w_applied   = 1'b0;
        unique case (r_state)
            CH_IDLE: begin
                w_count_nxt = '0;
                if (i_apply_v) begin
                    w_applied = 1'b1;
                    if (i_apply_en) begin
                        w_state_nxt = CH_RUN;
                        w_div_nxt   = i_apply_div;
                    end
                end
            end
            CH_RUN: begin
                if (w_tick) begin
                    w_count_nxt = '0;
                    if (i_apply_v) begin
                        w_applied = 1'b1;
                        if (i_apply_en) begin
                            w_div_nxt = i_apply_div;
                        end else begin
                            w_state_nxt = CH_IDLE;
                        end
                    end
                end else begin
                    w_count_nxt = r_count + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = CH_IDLE;
            end
        endcase
    end

    // High half is ceil(div/2) without overflowing at the max ratio.
    assign w_half_nxt = DIV_W'(w_div_nxt[DIV_W-1:1]) +
                        DIV_W'(w_div_nxt[0]);

    assign w_div_clk_nxt = (w_state_nxt == CH_RUN) &&
                           (w_count_nxt < w_half_nxt);

    // Channel state, counter, ratio and divided clock registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CH_IDLE;
            r_count   <= '0;
            r_div     <= DIV_W'(DIV_MIN);
            r_div_clk <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_div     <= w_div_nxt;
            r_div_clk <= w_div_clk_nxt;
        end
    end

    assign o_applied = w_applied;
    assign o_active  = (r_state == CH_RUN);
    assign o_tick    = w_tick;
    assign o_div_clk = r_div_clk;

endmodule

// File: rtl/clk_div_sched.sv
// Multi-channel clock-enable scheduler: one pending config slot
// shared by NUM_CH independent divided-clock channels.
module clk_div_sched
    import clk_sched_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DIV_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_clk
);

    cfg_req_t          r_pend;
    logic              r_pend_v;
    logic              r_err;
    logic              w_accept;
    logic              w_bad;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_applied;

    assign cfg_ready = !r_pend_v;
    assign cfg_err   = r_err;
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_bad     = {1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH);

    // Pending slot: filled on accept, freed when its channel applies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_v <= 1'b0;
            r_pend   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad;
            if (w_accept && !w_bad) begin
                r_pend_v <= 1'b1;
                r_pend   <= '{ch:  CH_W_MAX'(cfg_ch),
                              div: div_clamp(DIV_W_MAX'(cfg_div)),
                              en:  cfg_en};
            end else if (|w_applied) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_hit[i] = r_pend_v && (r_pend.ch == CH_W_MAX'(i));

        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_apply_v  (w_hit[i]),
            .i_apply_div(r_pend.div[DIV_W-1:0]),
            .i_apply_en (r_pend.en),
            .o_applied  (w_applied[i]),
            .o_active   (active[i]),
            .o_tick     (tick[i]),
            .o_div_clk  (div_clk[i])
        );
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: arithmetic schedule model
// per channel, expected output vectors queued and checked per cycle.
module tb_clk_div_sched;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int CW  = 2;
    localparam int LIM = 70000;

    logic           clk;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_en;
    logic           cfg_err;
    logic [NCH-1:0] active;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] div_clk;

    clk_div_sched #(
        .NUM_CH(NCH),
        .DIV_W (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_en   (cfg_en),
        .cfg_err  (cfg_err),
        .active   (active),
        .tick     (tick),
        .div_clk  (div_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] act;
        logic [NCH-1:0] tck;
        logic [NCH-1:0] dck;
        logic           rdy;
        logic           err;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;

    // Reference schedule: channel i runs ratio m_d from edge m_s.
    bit     m_run[NCH];
    longint m_s[NCH];
    longint m_d[NCH];
    bit     m_pend;
    int     m_ch;
    bit     m_en;
    longint m_div;
    longint m_apply;
    longint m_err_at;
    longint cyc = 0;

    task automatic model_step();
        exp_t   e;
        bit     rdy_old;
        int     c;
        longint ph;
        if (rst) begin
            for (int i = 0; i < NCH; i++) m_run[i] = 0;
            m_pend   = 0;
            m_err_at = -1;
            e        = '0;
            e.rdy    = 1'b1;
            q.push_back(e);
            return;
        end
        cyc++;
        rdy_old = !m_pend;
        if (m_pend && cyc == m_apply) begin
            if (m_en) begin
                m_run[m_ch] = 1;
                m_s[m_ch]   = cyc;
                m_d[m_ch]   = m_div;
            end else begin
                m_run[m_ch] = 0;
            end
            m_pend = 0;
        end
        if (cfg_valid && rdy_old) begin
            c = int'(cfg_ch);
            if (c >= NCH) begin
                m_err_at = cyc;
            end else begin
                m_pend = 1;
                m_ch   = c;
                m_en   = cfg_en;
                m_div  = (cfg_div == 0) ? 1 : longint'(cfg_div);
                if (m_run[c])
                    m_apply = m_s[c] + m_d[c] *
                        ((cyc + 1 - m_s[c] + m_d[c] - 1) / m_d[c]);
                else
                    m_apply = cyc + 1;
            end
        end
        e     = '0;
        e.rdy = !m_pend;
        e.err = (m_err_at == cyc);
        for (int i = 0; i < NCH; i++) begin
            if (m_run[i]) begin
                ph       = (cyc - m_s[i]) % m_d[i];
                e.act[i] = 1'b1;
                e.tck[i] = (ph == m_d[i] - 1);
                e.dck[i] = (ph < (m_d[i] + 1) / 2);
            end
        end
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {active, tick, div_clk, cfg_ready, cfg_err};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL vec t=%0t got %h expected %h",
                             $time, a, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int ch, input int dv, input bit en);
        int n;
        n = 0;
        @(negedge clk);
        cfg_ch    = ch[CW-1:0];
        cfg_div   = dv[DW-1:0];
        cfg_en    = en;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIM) begin
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int hi;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_active", 32'(active), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_divclk", 32'(div_clk), 0);
        chk("rst_err", 32'(cfg_err), 0);
        rst = 1'b0;

        // Reset in the middle of a running period.
        send(0, 4, 1'b1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_divclk", 32'(div_clk[0]), 0);
        chk("midrst_active", 32'(active[0]), 0);
        chk("midrst_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_idle", 32'(active[0]), 0);

        // Start idle ch1 at div=4 and check the waveform directly.
        send(1, 4, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk("start_active", 32'(active[1]), 1);
            chk("start_dclk", 32'(div_clk[1]), 32'((k % 4) < 2));
            chk("start_tick", 32'(tick[1]), 32'((k % 4) == 3));
        end

        // Ratio change mid-period, then stop with a stalled request.
        send(1, 3, 1'b1);
        repeat (5) @(negedge clk);
        send(1, 6, 1'b1);
        send(1, 0, 1'b0);
        send(2, 2, 1'b1);
        @(negedge clk);
        chk("stall_ch2_active", 32'(active[2]), 1);
        repeat (4) @(negedge clk);

        // Zero ratio behaves as div=1.
        send(0, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("div0_dclk", 32'(div_clk[0]), 1);
            chk("div0_tick", 32'(tick[0]), 1);
        end

        // Out-of-range channel.
        send(3, 5, 1'b1);
        chk("bad_err", 32'(cfg_err), 1);
        chk("bad_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        chk("bad_err_once", 32'(cfg_err), 0);

        // Randomized traffic against the model.
        for (int r = 0; r < 40; r++) begin
            send($urandom_range(0, 3), $urandom_range(0, 9),
                 $urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        // Maximum ratio on ch2.
        send(2, 0, 1'b0);
        send(2, 65535, 1'b1);
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (div_clk[2]) hi++;
        end while (!tick[2] && n < LIM);
        chk("max_period", n, 65535);
        chk("max_high", hi, 32768);

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
